// File: rtl/sensor_event_unit_pkg.sv
// Shared types for the sensor event unit: event kind, packed event record
// and the widths the queue and its consumer agree on.
package sensor_event_unit_pkg;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } evt_type_e;

  localparam int SLOT_W = 2;
  localparam int CNT_W  = 3;

  typedef struct packed {
    evt_type_e         etype;
    logic [SLOT_W-1:0] slot;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/sensor_event_unit_if.sv
// Event stream from the sensor unit to the parking controller, plus queue status.
interface sensor_event_unit_if;
  import sensor_event_unit_pkg::*;

  // Handshake: evt_valid stays high and evt_type/evt_slot stay stable until the
  // consumer raises evt_ready; the head event is consumed on every rising edge
  // where evt_valid && evt_ready, and evt_ready while evt_valid is low is ignored.
  logic              evt_valid;
  logic              evt_ready;
  logic              evt_type;
  logic [SLOT_W-1:0] evt_slot;
  logic [CNT_W-1:0]  evt_count;
  logic              overflow;

  modport master (
    output evt_valid,
    output evt_type,
    output evt_slot,
    output evt_count,
    output overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_type,
    input  evt_slot,
    input  evt_count,
    input  overflow,
    output evt_ready
  );

endinterface

// File: rtl/sensor_event_unit_debounce.sv
// One sensor channel: 2-flop synchronizer, run-length debounce and a registered
// one-cycle pulse on each accepted low-to-high change.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int               RUN_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic [RUN_W-1:0] run_q;
  logic             level_q;
  logic             armed_q;
  logic             rise_q;

  logic sample;
  logic differ;
  logic accept;

  always_comb begin
    sample = sync_q[1];
    differ = sample != level_q;
    accept = differ && (run_q == RUN_LAST);
  end

  // armed_q blocks the pulse for a sensor already high when reset released:
  // it only sets once a real synchronized sample has been seen low at a low level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      run_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fill_q <= {fill_q[0], 1'b1};
      if (!differ || accept) begin
        run_q <= '0;
      end else if (run_q != RUN_MAX) begin
        run_q <= run_q + RUN_W'(1);
      end
      if (accept) begin
        level_q <= sample;
      end
      rise_q <= accept && sample && armed_q;
      if (fill_q[1] && !level_q && !sample) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sensor_event_unit.sv
// Entry/exit gate sensors to a first-word-fall-through event queue; exit events
// carry the slot switch value and win over entry when both fire together.
module sensor_event_unit
  import sensor_event_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entry_sensor,
  input  logic              exit_sensor,
  input  logic [SLOT_W-1:0] switch,
  sensor_event_unit_if.master evt
);

  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic entry_rise;
  logic exit_rise;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (entry_sensor),
    .rise (entry_rise)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (exit_sensor),
    .rise (exit_rise)
  );

  evt_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             valid;
  logic             pop;
  logic [CNT_W-1:0] free_slots;
  logic             acc_exit;
  logic             acc_entry;
  logic             drop;
  logic [1:0]       n_push;
  evt_t             exit_evt;
  evt_t             entry_evt;
  evt_t             head;

  // A pop in the same cycle frees one slot for this cycle's pushes; exit
  // claims space first so that with one free slot the entry is the one dropped.
  always_comb begin
    valid      = count_q != '0;
    pop        = valid && evt.evt_ready;
    free_slots = DEPTH_C - count_q + CNT_W'(pop);
    acc_exit   = exit_rise && (free_slots != '0);
    acc_entry  = entry_rise && (free_slots > CNT_W'(acc_exit));
    drop       = (exit_rise && !acc_exit) || (entry_rise && !acc_entry);
    n_push     = {1'b0, acc_exit} + {1'b0, acc_entry};
    exit_evt   = '{etype: EXIT, slot: switch};
    entry_evt  = '{etype: ENTRY, slot: '0};
    head       = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      count_q  <= count_q + CNT_W'(n_push) - CNT_W'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (acc_exit) begin
      mem_q[wr_ptr_q] <= exit_evt;
    end
    if (acc_entry) begin
      mem_q[wr_ptr_q + PTR_W'(acc_exit)] <= entry_evt;
    end
  end

  assign evt.evt_valid = valid;
  assign evt.evt_type  = valid ? head.etype : ENTRY;
  assign evt.evt_slot  = valid ? head.slot : '0;
  assign evt.evt_count = count_q;
  assign evt.overflow  = overflow_q;

endmodule

// File: tb/tb_sensor_event_unit.sv
// Bench for sensor_event_unit: directed scenarios plus randomized sensor traffic,
// every cycle compared against a window-based behavioural model.
module tb_sensor_event_unit;
  import sensor_event_unit_pkg::*;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [1:0] sw = 2'b00;

  always #5 clk = ~clk;

  sensor_event_unit_if bus ();

  sensor_event_unit #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .entry_sensor(entry_sensor),
    .exit_sensor (exit_sensor),
    .switch      (sw),
    .evt         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: a sensor's level flips when the last D synchronized samples all
  // disagree with it; a flip to 1 becomes an event one cycle later if armed.
  logic [EVT_W-1:0] exp_q[$];
  bit               m_ovf;
  int               m_edges;
  bit [1:0]         m_pipe  [2];
  bit [D-1:0]       m_win   [2];
  int               m_win_n [2];
  bit               m_lvl   [2];
  bit               m_armed [2];
  bit               m_pend  [2];

  task automatic model_step();
    bit raw [2];
    bit s;
    bit rise_now;
    bit old_lvl;
    raw[0] = entry_sensor;
    raw[1] = exit_sensor;
    if (!rst_n) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_edges = 0;
      for (int i = 0; i < 2; i++) begin
        m_pipe[i]  = '0;
        m_win[i]   = '0;
        m_win_n[i] = 0;
        m_lvl[i]   = 1'b0;
        m_armed[i] = 1'b0;
        m_pend[i]  = 1'b0;
      end
      return;
    end
    m_edges++;
    if (exp_q.size() > 0 && bus.evt_ready) void'(exp_q.pop_front());
    if (m_pend[1]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({1'b1, sw});
      else m_ovf = 1'b1;
    end
    if (m_pend[0]) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(3'b000);
      else m_ovf = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      s         = m_pipe[i][1];
      m_pipe[i] = {m_pipe[i][0], raw[i]};
      m_win[i]  = {m_win[i][D-2:0], s};
      if (m_win_n[i] < D) m_win_n[i]++;
      old_lvl  = m_lvl[i];
      rise_now = 1'b0;
      if (m_win_n[i] == D && m_win[i] == {D{!old_lvl}}) begin
        rise_now = s && m_armed[i];
        m_lvl[i] = s;
      end
      if (m_edges >= 3 && !old_lvl && !s) m_armed[i] = 1'b1;
      m_pend[i] = rise_now;
    end
  endtask

  task automatic compare_outputs();
    logic [2:0] hd;
    hd = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
    check("valid", 16'(bus.evt_valid), 16'(exp_q.size() != 0));
    check("count", 16'(bus.evt_count), 16'(exp_q.size()));
    check("overflow", 16'(bus.overflow), 16'(m_ovf));
    check("type", 16'(bus.evt_type), 16'(hd[2]));
    check("slot", 16'(bus.evt_slot), 16'(hd[1:0]));
  endtask

  // driver: inputs change #1 after the edge, outputs are checked there too
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int lat;
  int hi_cnt;
  int max_cnt;
  int seen;
  int hold_e;
  int hold_x;

  initial begin
    bus.evt_ready = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);

    // entry latency and single-cycle event with a ready consumer
    bus.evt_ready = 1'b1;
    entry_sensor  = 1'b1;
    lat = 0;
    hi_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.evt_valid) begin
        hi_cnt++;
        if (lat == 0) lat = i;
      end
    end
    check("latency", 16'(lat), 16'(D + 3));
    check("pulse_len", 16'(hi_cnt), 16'd1);
    entry_sensor = 1'b0;
    idle(10);

    // short exit glitch is filtered
    max_cnt = 0;
    exit_sensor = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (int'(bus.evt_count) > max_cnt) max_cnt = int'(bus.evt_count);
    end
    exit_sensor = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (int'(bus.evt_count) > max_cnt) max_cnt = int'(bus.evt_count);
    end
    check("glitch_cnt", 16'(max_cnt), 16'd0);

    // slot captured at the event, later switch changes do not leak in
    bus.evt_ready = 1'b0;
    sw = 2'b10;
    exit_sensor = 1'b1;
    seen = 0;
    for (int i = 0; i < 15 && seen == 0; i++) begin
      tick();
      if (bus.evt_valid) seen = 1;
    end
    check("exit_seen", 16'(seen), 16'd1);
    tick();
    sw = 2'b01;
    idle(3);
    check("exit_slot", 16'(bus.evt_slot), 16'h2);
    check("exit_type", 16'(bus.evt_type), 16'h1);
    bus.evt_ready = 1'b1;
    exit_sensor = 1'b0;
    idle(10);

    // simultaneous events: exit ahead of entry
    bus.evt_ready = 1'b0;
    entry_sensor = 1'b1;
    exit_sensor  = 1'b1;
    idle(12);
    check("both_cnt", 16'(bus.evt_count), 16'd2);
    check("both_head", 16'(bus.evt_type), 16'h1);
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
    check("both_next", 16'(bus.evt_type), 16'h0);
    check("both_cnt1", 16'(bus.evt_count), 16'd1);
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    bus.evt_ready = 1'b1;
    idle(10);

    // five entry pulses into a four-deep queue, then reset
    bus.evt_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      entry_sensor = 1'b1;
      idle(D + 2);
      entry_sensor = 1'b0;
      idle(D + 2);
    end
    idle(4);
    check("full_cnt", 16'(bus.evt_count), 16'(DEPTH));
    check("full_ovf", 16'(bus.overflow), 16'd1);
    rst_n = 1'b0;
    tick();
    check("rst_valid", 16'(bus.evt_valid), 16'd0);
    check("rst_cnt", 16'(bus.evt_count), 16'd0);
    check("rst_ovf", 16'(bus.overflow), 16'd0);
    check("rst_type", 16'(bus.evt_type), 16'd0);
    check("rst_slot", 16'(bus.evt_slot), 16'd0);
    rst_n = 1'b1;
    idle(5);

    // sensor held high across reset release emits nothing until it re-rises
    bus.evt_ready = 1'b1;
    entry_sensor = 1'b1;
    idle(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.evt_valid) hi_cnt++;
    end
    check("held_none", 16'(hi_cnt), 16'd0);
    entry_sensor = 1'b0;
    idle(8);
    bus.evt_ready = 1'b0;
    entry_sensor = 1'b1;
    idle(10);
    check("rerise_cnt", 16'(bus.evt_count), 16'd1);
    bus.evt_ready = 1'b1;
    entry_sensor = 1'b0;
    idle(10);

    // randomized traffic: mixed glitches and real events, light then heavy backpressure
    hold_e = 0;
    hold_x = 0;
    for (int c = 0; c < 1600; c++) begin
      if (hold_e == 0) begin
        entry_sensor = 1'($urandom_range(0, 1));
        hold_e = $urandom_range(1, 9);
      end
      if (hold_x == 0) begin
        exit_sensor = 1'($urandom_range(0, 1));
        hold_x = $urandom_range(1, 9);
      end
      hold_e--;
      hold_x--;
      if (c % 23 == 0) sw = 2'($urandom_range(0, 3));
      if (c < 800) bus.evt_ready = ($urandom_range(0, 3) != 0);
      else bus.evt_ready = ($urandom_range(0, 4) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_event_unit.md
SENSOR_EVENT_UNIT -- requirements
Module: sensor_event_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable synchronized samples needed to accept a sensor level change; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue depth; power of two, minimum 2.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 entry_sensor  input  1  raw, asynchronous entry gate sensor; high = car present.
REQ-006 exit_sensor  input  1  raw, asynchronous exit gate sensor; high = car present.
REQ-007 switch  input  2  slot index of the departing car; quasi-static, sampled only on exit events.
REQ-008 evt_valid  output  1  head of queue holds an event.
REQ-009 evt_ready  input  1  consumer (parking FSM) accepts head event this cycle.
REQ-010 evt_type  output  1  0 = entry, 1 = exit.
REQ-011 evt_slot  output  2  slot index for exit events; 2'b00 for entry events.
REQ-012 evt_count  output  3  events currently queued, 0..FIFO_DEPTH.
REQ-013 overflow  output  1  sticky; an event was dropped.

Function
REQ-014 Each sensor passes through a 2-flop synchronizer before any other use.
REQ-015 Debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample in between clears the run counter to 0.
REQ-016 Debounce counter saturates at DEBOUNCE_CYCLES; no wrap-around.
REQ-017 A debounced 0->1 transition produces exactly one event; 1->0 transitions produce none.
REQ-018 Exit event captures switch in the same cycle as the debounced 0->1 transition.
REQ-019 Queue is first-word-fall-through; an event enqueued at edge N is visible on evt_* after edge N.
REQ-020 Latency raw sensor rise -> evt_valid high on an empty queue = DEBOUNCE_CYCLES + 3 cycles.
REQ-021 Pop occurs on each edge where evt_valid && evt_ready; evt_ready while evt_valid is low has no effect.
REQ-022 evt_type/evt_slot hold stable while evt_valid && !evt_ready.
REQ-023 Simultaneous entry and exit events in one cycle: exit enqueued first, entry second.
REQ-024 Push to a full queue is dropped and sets overflow, except when a pop occurs in the same cycle, in which case one push is accepted.
REQ-025 With one free slot and two simultaneous events: exit accepted, entry dropped, overflow set.
REQ-026 overflow clears only on reset.
REQ-027 evt_count updates on the same edge as push/pop; simultaneous push+pop leaves it unchanged.

Reset
REQ-028 While rst_n is sampled low: synchronizers, debounced levels and counters 0; queue empty; evt_valid 0; evt_type 0; evt_slot 0; evt_count 0; overflow 0.
REQ-029 Reset asserted mid-debounce or with a non-empty queue discards all pending state; no event is emitted for a sensor held high across reset release until it goes low and rises again.

Structure
REQ-030 Shared package holds the event-type enumeration (ENTRY, EXIT), the packed event record {type, slot} and its width constant.
REQ-031 Debounce-and-edge logic is one sub-module, sensor_debounce, instantiated once per sensor; queue is inline.

Verification
REQ-032 DEBOUNCE_CYCLES=4, entry_sensor rises and stays high, evt_ready=1 -> evt_valid high exactly 7 cycles later for one cycle, evt_type=0, evt_slot=0.
REQ-033 exit_sensor glitches high 3 cycles then low (DEBOUNCE_CYCLES=4) -> no event; evt_count stays 0.
REQ-034 switch=2'b10, exit_sensor rises, switch changes to 2'b01 two cycles later -> exit event with evt_slot=2'b10.
REQ-035 evt_ready=0, both sensors rise in the same cycle -> evt_count=2, head is exit; after one pop, head is entry.
REQ-036 evt_ready=0, 5 entry pulses (FIFO_DEPTH=4) -> evt_count=4, overflow=1; rst_n low one cycle -> all outputs 0, overflow 0.
